register_file: RTL and testbench
================================

Name: register_file

Overview:
- 32-entry x 32-bit general-purpose register file for the single-cycle datapath.
- Directly upstream of the shift/ALU stage: the rt read port supplies the operand that the logical right shifter consumes (R[rd] = R[rt] >> shamt), and the rs read port supplies the other ALU operand.
- Writeback from the ALU/shifter result returns through the single write port on the clock edge that ends the instruction.

Parameters:
- DATA_WIDTH, 32, width of each register and of every data port.
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH (32).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- rs_addr  input  ADDR_WIDTH  read port A index (instr[25:21]).
- rt_addr  input  ADDR_WIDTH  read port B index (instr[20:16]).
- wr_en  input  1  write enable (RegWrite).
- wr_addr  input  ADDR_WIDTH  write index (rd or rt, selected upstream).
- wr_data  input  DATA_WIDTH  writeback value (ALU/shifter/memory result).
- rs_data  output  DATA_WIDTH  contents of R[rs_addr].
- rt_data  output  DATA_WIDTH  contents of R[rt_addr]; feeds the shifter A input.

Behaviour:
- Storage: 32 registers of DATA_WIDTH bits, indexed 0..31.
- Reset:
  - Asserting reset immediately clears all 32 registers to 0, without waiting for a clock edge.
  - While reset is high, rs_data = rt_data = 0 and all writes are ignored.
  - Deassertion needs no settling cycle; the first rising edge with reset low and wr_en high performs a write.
- Reads:
  - Combinational, with zero cycles of latency.
  - rs_data = R[rs_addr] and rt_data = R[rt_addr], updated within the same cycle the address changes.
  - Both ports are independent; the same index on both ports returns the same value.
- Writes:
  - On a rising clk edge with reset low and wr_en = 1, R[wr_addr] <= wr_data.
  - With wr_en = 0 the contents are unchanged.
- Register 0:
  - Hardwired to zero.
  - Writes to index 0 are discarded, so reads of index 0 always return 0, including under the bypass feature.
- Read-during-write, same index, bypass disabled:
  - The read port returns the old value for the rest of the cycle.
  - The new value becomes visible after the edge.
- Reset mid-operation: reset rising in the same cycle as a pending write has priority; the write is lost and the target register reads 0.
- X-safety: unknown wr_data is written as-is; wr_en = 0 never disturbs the contents.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding on both ports.
  - If wr_en = 1, wr_addr != 0, reset = 0 and wr_addr == rs_addr (or rt_addr), that port outputs wr_data combinationally in the same cycle.
  - The register is still updated at the edge.
- Undefined:
  - No forwarding; reads return stored contents only, as described in Behaviour.
  - No extra logic is instantiated.

Test Plan:
- Reset clears: write 0xDEADBEEF to R5, then pulse reset between clock edges -> rt_data with rt_addr=5 reads 0x00000000 immediately, before any edge.
- Basic write/read: wr_en=1, wr_addr=9, wr_data=0x80000000, then one edge; read with rt_addr=9, rs_addr=9 -> both ports read 0x80000000 (shifter operand check: shamt 31 yields 0x00000001 downstream).
- R0 immutability: wr_en=1, wr_addr=0, wr_data=0xFFFFFFFF, then edge -> rs_data with rs_addr=0 reads 0 (bypass build also returns 0 during the write cycle).
- wr_en low: R3=0x12345678; apply wr_en=0, wr_addr=3, wr_data=0 over 4 edges -> R3 still 0x12345678.
- Read-during-write: R7=0x11111111; in one cycle set wr_en=1, wr_addr=7, wr_data=0x22222222, rt_addr=7:
  - Without REGFILE_BYPASS_EN -> rt_data=0x11111111 before the edge and 0x22222222 after.
  - With REGFILE_BYPASS_EN -> rt_data=0x22222222 before the edge.
- Reset priority: assert reset in the same cycle as wr_en=1, wr_addr=12, wr_data=0xA5A5A5A5 -> after reset releases, R12 reads 0.

Source files
------------

// File: rtl/register_file.sv
// register_file: 32 x DATA_WIDTH GPR file, two combinational read ports (rs, rt), one write port.
// Latency: reads 0 cycles; writes land at the rising clk edge (forwarded same-cycle when REGFILE_BYPASS_EN is defined).
// Backpressure: none; every enabled write is accepted, reset clears asynchronously and discards writes.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rs_addr,
  input  logic [ADDR_WIDTH-1:0] rt_addr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rs_data,
  output logic [DATA_WIDTH-1:0] rt_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];

  // A write only counts when it targets a nonzero index; R0 stays hardwired to zero.
  logic wr_hit;
  assign wr_hit = wr_en && (wr_addr != '0);

  // Next-state: hold every entry, replace the addressed one, pin entry 0 to zero.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_hit) begin
      regs_d[wr_addr] = wr_data;
    end
    regs_d[0] = '0;
  end

  // Storage: reset clears everything immediately, otherwise capture next state on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is suppressed during reset so both ports read zero while it is held.
  logic byp_vld;
  assign byp_vld = wr_hit && !reset;

  // Read ports: stored value, overridden by the in-flight write to the same nonzero index.
  always_comb begin
    rs_data = regs_q[rs_addr];
    rt_data = regs_q[rt_addr];
    if (byp_vld && (wr_addr == rs_addr)) begin
      rs_data = wr_data;
    end
    if (byp_vld && (wr_addr == rt_addr)) begin
      rt_data = wr_data;
    end
  end
`else
  // Read ports: stored contents only; a same-index write shows up after the edge.
  always_comb begin
    rs_data = regs_q[rs_addr];
    rt_data = regs_q[rt_addr];
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed scenarios plus randomized traffic against an array reference model.
// Inputs change on the falling edge; combinational reads are sampled 1ns after each change.
// Reset is pulsed between edges to exercise the asynchronous clear.
module tb_register_file;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] rs_addr, rt_addr, wr_addr;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rs_data, rt_data;

  logic [DW-1:0] ref_mem [32];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
  endtask

  // Expected read value from the architectural rules.
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (reset || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a) return wr_data;
`endif
    return ref_mem[a];
  endfunction

  // One clock: model commits the write at the rising edge, returns at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (!reset && wr_en && wr_addr != 0) ref_mem[wr_addr] = wr_data;
    @(negedge clk);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    clear_model();
    #1;
    chk("rst_rs_zero", rs_data, '0);
    chk("rst_rt_zero", rt_data, '0);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rs_addr = 5'd5; rt_addr = 5'd31;
    clear_model();
    #2;
    chk("reset_rs", rs_data, '0);
    chk("reset_rt", rt_data, '0);
    @(negedge clk);
    reset = 1'b0;

    // Reset clears between edges
    wr(5'd5, 32'hDEADBEEF);
    rt_addr = 5'd5;
    #1 chk("r5_written", rt_data, 32'hDEADBEEF);
    reset = 1'b1;
    clear_model();
    #1 chk("r5_async_clear", rt_data, 32'h0);
    reset = 1'b0;
    #1 chk("r5_after_release", rt_data, 32'h0);
    @(negedge clk);

    // Basic write / read on both ports, shifter operand
    wr(5'd9, 32'h80000000);
    rs_addr = 5'd9; rt_addr = 5'd9;
    #1;
    chk("r9_rs", rs_data, 32'h80000000);
    chk("r9_rt", rt_data, 32'h80000000);
    chk("r9_shr31", rt_data >> 31, 32'h00000001);
    @(negedge clk);

    // R0 immutability, including during the write cycle
    rs_addr = 5'd0;
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    #1 chk("r0_during_write", rs_data, 32'h0);
    tick();
    wr_en = 1'b0;
    #1 chk("r0_after_write", rs_data, 32'h0);
    @(negedge clk);

    // wr_en low leaves contents alone
    wr(5'd3, 32'h12345678);
    wr_en = 1'b0; wr_addr = 5'd3; wr_data = 32'h0;
    repeat (4) tick();
    rs_addr = 5'd3;
    #1 chk("r3_hold", rs_data, 32'h12345678);
    @(negedge clk);

    // Read during write, same index
    wr(5'd7, 32'h11111111);
    rt_addr = 5'd7;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h22222222;
`ifdef REGFILE_BYPASS_EN
    #1 chk("rdw_before_edge", rt_data, 32'h22222222);
`else
    #1 chk("rdw_before_edge", rt_data, 32'h11111111);
`endif
    tick();
    wr_en = 1'b0;
    #1 chk("rdw_after_edge", rt_data, 32'h22222222);
    @(negedge clk);

    // Reset has priority over a pending write
    wr(5'd12, 32'h0000005A);
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hA5A5A5A5;
    reset = 1'b1;
    clear_model();
    tick();
    reset = 1'b0; wr_en = 1'b0;
    rs_addr = 5'd12;
    #1 chk("r12_reset_priority", rs_data, 32'h0);
    @(negedge clk);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rs_addr = AW'($urandom_range(0, 31));
      rt_addr = AW'($urandom_range(0, 31));
      wr_en   = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       wr_addr = rs_addr;
        1:       wr_addr = rt_addr;
        default: wr_addr = AW'($urandom_range(0, 31));
      endcase
      wr_data = $urandom;
      #1;
      chk("rand_rs", rs_data, exp_rd(rs_addr));
      chk("rand_rt", rt_data, exp_rd(rt_addr));
      if ($urandom_range(0, 49) == 0) pulse_reset();
      tick();
    end

    // Final sweep of every register through both ports
    wr_en = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rs_addr = AW'(a);
      rt_addr = AW'(31 - a);
      #1;
      chk("sweep_rs", rs_data, exp_rd(rs_addr));
      chk("sweep_rt", rt_data, exp_rd(rt_addr));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
